// File: rtl/uart_msg_tx_if.sv
// Message handshake and UART line bundle for uart_msg_tx.
// master: the message builder that presents a message and watches the line.
// slave : the transmitter itself.
interface uart_msg_tx_if #(
  parameter int MAX_BYTES = 12,
  parameter int REPEAT_W  = 3
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  logic [8*MAX_BYTES-1:0] TX_DATA;
  logic [LEN_W-1:0]       TX_LEN;
  logic [REPEAT_W-1:0]    TX_REPEAT;
  logic                   TX_VALID;
  logic                   TX_READY;
  logic                   O_TX_SERIAL;
  logic                   O_TX_BUSY;
  logic                   O_TX_DONE;
  logic [IDX_W-1:0]       O_BYTE_IDX;

  modport master (
    output TX_DATA, TX_LEN, TX_REPEAT, TX_VALID,
    input  TX_READY, O_TX_SERIAL, O_TX_BUSY, O_TX_DONE, O_BYTE_IDX
  );

  modport slave (
    input  TX_DATA, TX_LEN, TX_REPEAT, TX_VALID,
    output TX_READY, O_TX_SERIAL, O_TX_BUSY, O_TX_DONE, O_BYTE_IDX
  );
endinterface

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: multi-byte UART message transmitter with inter-byte idle gap
// and whole-message repetition. All outputs are registered.
// Optional feature macro: UART_MSG_TX_PARITY_EN adds a parity bit after the
// data bits (even by default, odd when PARITY_ODD=1).
module uart_msg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_BYTES    = 12,
  parameter int GAP_CLKS     = 8661,
  parameter int REPEAT_W     = 3,
  parameter int STOP_BITS    = 1
`ifdef UART_MSG_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input logic          CLOCK,
  input logic          RESET,
  uart_msg_tx_if.slave bus
);
  localparam int LEN_W    = $clog2(MAX_BYTES + 1);
  localparam int IDX_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int STOP_CLK = STOP_BITS * CLKS_PER_BIT;
  localparam int SPAN_A   = (STOP_CLK > GAP_CLKS) ? STOP_CLK : GAP_CLKS;
  localparam int CNT_SPAN = (SPAN_A > 2) ? SPAN_A : 2;
  localparam int CNT_W    = $clog2(CNT_SPAN);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLK - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_GAP    = 3'd4,
    S_FIN    = 3'd5
`ifdef UART_MSG_TX_PARITY_EN
    , S_PARITY = 3'd6
`endif
  } state_e;

`ifdef UART_MSG_TX_PARITY_EN
  // Parity over the data byte; odd flips the even result.
  function automatic logic parity_f(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction
`endif

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [REPEAT_W-1:0]    rep_q, rep_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic                   serial_q, serial_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [8*MAX_BYTES-1:0] shifted_s;
  logic [7:0]             cur_byte_s;
  logic [LEN_W-1:0]       len_in_s;
  logic [REPEAT_W-1:0]    rep_in_s;
  logic                   last_byte_s;
  logic                   last_frame_s;
  logic [IDX_W-1:0]       nxt_idx_s;
  logic [REPEAT_W-1:0]    nxt_rep_s;

  // Next-state, datapath and next-output decode; outputs follow the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    rep_d      = rep_q;
    len_d      = len_q;
    data_d     = data_q;
    serial_d   = serial_q;
    done_d     = 1'b0;

    shifted_s  = data_q >> {byte_idx_q, 3'b000};
    cur_byte_s = shifted_s[7:0];
    len_in_s   = (bus.TX_LEN > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : bus.TX_LEN;
    rep_in_s   = (bus.TX_REPEAT == {REPEAT_W{1'b0}}) ? REPEAT_W'(1) : bus.TX_REPEAT;

    last_byte_s  = (LEN_W'(byte_idx_q) == (len_q - LEN_W'(1)));
    last_frame_s = last_byte_s && (rep_q == REPEAT_W'(1));
    // On the last byte of a pass, wrap to byte 0 and use up one repetition.
    nxt_idx_s    = last_byte_s ? {IDX_W{1'b0}} : (byte_idx_q + IDX_W'(1));
    nxt_rep_s    = last_byte_s ? (rep_q - REPEAT_W'(1)) : rep_q;

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        if (bus.TX_VALID) begin
          data_d     = bus.TX_DATA;
          len_d      = len_in_s;
          rep_d      = rep_in_s;
          byte_idx_d = {IDX_W{1'b0}};
          bit_idx_d  = 3'd0;
          cnt_d      = {CNT_W{1'b0}};
          if (len_in_s == {LEN_W{1'b0}}) begin
            state_d = S_FIN;
          end else begin
            state_d  = S_START;
            serial_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = {CNT_W{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          serial_d  = cur_byte_s[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_MSG_TX_PARITY_EN
            state_d  = S_PARITY;
            serial_d = parity_f(cur_byte_s, PARITY_ODD);
`else
            state_d  = S_STOP;
            serial_d = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = cur_byte_s[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_MSG_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = {CNT_W{1'b0}};
          state_d  = S_STOP;
          serial_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        serial_d = 1'b1;
        if (cnt_q == STOP_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (last_frame_s) begin
            state_d    = S_FIN;
            done_d     = 1'b1;
            byte_idx_d = {IDX_W{1'b0}};
          end else if (GAP_CLKS > 0) begin
            state_d = S_GAP;
          end else begin
            state_d    = S_START;
            serial_d   = 1'b0;
            byte_idx_d = nxt_idx_s;
            rep_d      = nxt_rep_s;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        serial_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d      = {CNT_W{1'b0}};
          state_d    = S_START;
          serial_d   = 1'b0;
          byte_idx_d = nxt_idx_s;
          rep_d      = nxt_rep_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A zero-length message reaches FIN without the pulse armed, so it
      // spends one extra cycle here before DONE fires.
      S_FIN: begin
        serial_d = 1'b1;
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE) && !done_d;
  end

  // State and output registers with synchronous reset to the idle line.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      bit_idx_q  <= 3'd0;
      byte_idx_q <= {IDX_W{1'b0}};
      rep_q      <= {REPEAT_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      data_q     <= {(8*MAX_BYTES){1'b0}};
      serial_q   <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      rep_q      <= rep_d;
      len_q      <= len_d;
      data_q     <= data_d;
      serial_q   <= serial_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.TX_READY    = ready_q;
  assign bus.O_TX_SERIAL = serial_q;
  assign bus.O_TX_BUSY   = busy_q;
  assign bus.O_TX_DONE   = done_q;
  assign bus.O_BYTE_IDX  = byte_idx_q;
endmodule

// File: tb/tb_uart_msg_tx.sv
// Testbench for uart_msg_tx: a message-level model expands each accepted
// message into the expected per-cycle line/status sequence; every cycle is
// compared, and directed tests pin key timings with literal values.
module tb_uart_msg_tx;
  localparam int CPB  = 4;
  localparam int MAXB = 4;
  localparam int GAP  = 2;
  localparam int RW   = 3;
  localparam int SB   = 1;
  localparam bit PODD = 1'b0;
`ifdef UART_MSG_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FR = CPB * (9 + PB + SB);  // cycles per byte frame

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_msg_tx_if #(.MAX_BYTES(MAXB), .REPEAT_W(RW)) bus_if ();

  uart_msg_tx #(
    .CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB), .GAP_CLKS(GAP),
    .REPEAT_W(RW), .STOP_BITS(SB)
`ifdef UART_MSG_TX_PARITY_EN
    , .PARITY_ODD(PODD)
`endif
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (bus_if)
  );

  typedef struct packed {
    logic       ser;
    logic       busy;
    logic       done;
    logic       ready;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  logic model_ready = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic line[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Expand one accepted message into its expected cycle-by-cycle outputs.
  task automatic build(input logic [31:0] d, input logic [2:0] len, input logic [2:0] rep);
    int l;
    int r;
    logic [7:0] b8;
    logic bv;
    exp_t e;
    l = (len > 3'd4) ? 4 : int'(len);
    r = (rep == 3'd0) ? 1 : int'(rep);
    if (l == 0) begin
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      q.push_back(e);
    end else begin
      for (int ri = 0; ri < r; ri++) begin
        for (int bi = 0; bi < l; bi++) begin
          b8 = d[8*bi +: 8];
          for (int k = 0; k < 9 + PB + SB; k++) begin
            if (k == 0) bv = 1'b0;
            else if (k <= 8) bv = b8[k-1];
            else if (PB == 1 && k == 9) bv = (^b8) ^ PODD;
            else bv = 1'b1;
            e = '{bv, 1'b1, 1'b0, 1'b0, 2'(bi)};
            repeat (CPB) q.push_back(e);
          end
          if (!(ri == r - 1 && bi == l - 1)) begin
            e = '{1'b1, 1'b1, 1'b0, 1'b0, 2'(bi)};
            repeat (GAP) q.push_back(e);
          end
        end
      end
    end
    e = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    q.push_back(e);
  endtask

  // Model update at the clock edge, then compare every DUT output 1 unit later.
  always @(posedge clk) begin
    exp_t e;
    if (rst) q.delete();
    else if (bus_if.TX_VALID && model_ready)
      build(bus_if.TX_DATA, bus_if.TX_LEN, bus_if.TX_REPEAT);
    #1;
    if (q.size() > 0) e = q.pop_front();
    else e = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    model_ready = e.ready;
    chk("serial", 32'(bus_if.O_TX_SERIAL), 32'(e.ser));
    chk("busy",   32'(bus_if.O_TX_BUSY),   32'(e.busy));
    chk("done",   32'(bus_if.O_TX_DONE),   32'(e.done));
    chk("ready",  32'(bus_if.TX_READY),    32'(e.ready));
    chk("idx",    32'(bus_if.O_BYTE_IDX),  32'(e.idx));
  end

  task automatic send(input logic [31:0] d, input logic [2:0] len, input logic [2:0] rep);
    @(negedge clk);
    bus_if.TX_DATA   = d;
    bus_if.TX_LEN    = len;
    bus_if.TX_REPEAT = rep;
    bus_if.TX_VALID  = 1'b1;
    @(negedge clk);
    bus_if.TX_VALID  = 1'b0;
  endtask

  // Starting at cycle 1 after acceptance, record the line until DONE.
  task automatic wait_done(input int limit, output int k_out, output int busy_out);
    int k;
    bit found;
    k = 1;
    busy_out = 0;
    found = 1'b0;
    line.delete();
    while (k <= limit && !found) begin
      line.push_back(bus_if.O_TX_SERIAL);
      if (bus_if.O_TX_BUSY === 1'b1) busy_out++;
      if (bus_if.O_TX_DONE === 1'b1) found = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!found) begin
      chk("done_timeout", 32'(k), 32'(0));
      k_out = -1;
    end else begin
      k_out = k;
    end
  endtask

  initial begin
    int k;
    int b;
    int dcnt;
    logic [9:0] pat;
    pat = 10'b1101001010;  // A5 frame: start, 1,0,1,0,0,1,0,1, stop (bit 0 first)
    bus_if.TX_DATA   = 32'h0;
    bus_if.TX_LEN    = 3'd0;
    bus_if.TX_REPEAT = 3'd0;
    bus_if.TX_VALID  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(bus_if.O_TX_SERIAL), 32'd1);
    chk("rst_ready",  32'(bus_if.TX_READY),    32'd1);
    chk("rst_busy",   32'(bus_if.O_TX_BUSY),   32'd0);
    chk("rst_done",   32'(bus_if.O_TX_DONE),   32'd0);
    chk("rst_idx",    32'(bus_if.O_BYTE_IDX),  32'd0);
    rst = 1'b0;

    // Single byte 0xA5.
    send(32'h000000A5, 3'd1, 3'd1);
    wait_done(400, k, b);
    chk("a5_done_cycle", 32'(k), 32'(FR + 1));
    if (PB == 0) begin
      for (int j = 0; j < 10; j++) chk("a5_line_bit", 32'(line[1 + 4*j]), 32'(pat[j]));
    end
    @(negedge clk);
    chk("a5_ready_after", 32'(bus_if.TX_READY), 32'd1);

    // Three bytes; inputs change after acceptance and must be ignored.
    send(32'h00332211, 3'd3, 3'd1);
    bus_if.TX_DATA = 32'hFFFFFFFF;
    bus_if.TX_LEN  = 3'd0;
    wait_done(800, k, b);
    chk("multi_done_cycle", 32'(k), 32'(3*FR + 2*GAP + 1));
    chk("multi_busy_cycles", 32'(b), 32'(3*FR + 2*GAP));

    // Two bytes repeated three times.
    send(32'h0000BBAA, 3'd2, 3'd3);
    wait_done(2000, k, b);
    chk("rep3_done_cycle", 32'(k), 32'(6*FR + 5*GAP + 1));

    // REPEAT=0 behaves as one pass.
    send(32'h0000005C, 3'd1, 3'd0);
    wait_done(400, k, b);
    chk("rep0_done_cycle", 32'(k), 32'(FR + 1));

    // Zero length: no frame, DONE two cycles after acceptance.
    send(32'h000000FF, 3'd0, 3'd1);
    wait_done(50, k, b);
    chk("len0_done_cycle", 32'(k), 32'd2);

    // Length 7 clamps to 4 bytes.
    send(32'h44332211, 3'd7, 3'd1);
    wait_done(1000, k, b);
    chk("len7_done_cycle", 32'(k), 32'(4*FR + 3*GAP + 1));
    chk("len7_busy_cycles", 32'(b), 32'(4*FR + 3*GAP));

    // VALID held high: second message only after READY returns.
    @(negedge clk);
    bus_if.TX_DATA   = 32'h0000003C;
    bus_if.TX_LEN    = 3'd1;
    bus_if.TX_REPEAT = 3'd1;
    bus_if.TX_VALID  = 1'b1;
    @(negedge clk);
    wait_done(400, k, b);
    chk("held_done_cycle", 32'(k), 32'(FR + 1));
    @(negedge clk);
    chk("held_ready_gap", 32'(bus_if.TX_READY), 32'd1);
    chk("held_line_idle", 32'(bus_if.O_TX_SERIAL), 32'd1);
    @(negedge clk);
    chk("held_restart_start", 32'(bus_if.O_TX_SERIAL), 32'd0);
    chk("held_restart_busy",  32'(bus_if.O_TX_BUSY),   32'd1);
    bus_if.TX_VALID = 1'b0;
    wait_done(400, k, b);
    chk("held_second_done", 32'(k), 32'(FR + 1));

`ifdef UART_MSG_TX_PARITY_EN
    send(32'h000000A5, 3'd1, 3'd1);
    wait_done(400, k, b);
    chk("par_frame_done", 32'(k), 32'd45);
    chk("par_a5", 32'(line[37]), 32'(1'b0 ^ PODD));
    send(32'h00000007, 3'd1, 3'd1);
    wait_done(400, k, b);
    chk("par_07", 32'(line[37]), 32'(1'b1 ^ PODD));
`endif

    // Reset in the middle of data bit 3 of byte 1 (byte 1 = 0x5A, bit 3 = 1).
    send(32'h00005A11, 3'd2, 3'd1);
    repeat (FR + 20) @(negedge clk);
    chk("pre_rst_idx",  32'(bus_if.O_BYTE_IDX),  32'd1);
    chk("pre_rst_bit3", 32'(bus_if.O_TX_SERIAL), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_serial", 32'(bus_if.O_TX_SERIAL), 32'd1);
    chk("post_rst_ready",  32'(bus_if.TX_READY),    32'd1);
    chk("post_rst_busy",   32'(bus_if.O_TX_BUSY),   32'd0);
    chk("post_rst_done",   32'(bus_if.O_TX_DONE),   32'd0);
    dcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_if.O_TX_DONE === 1'b1) dcnt++;
    end
    chk("post_rst_no_done", 32'(dcnt), 32'd0);
    send(32'h000000A5, 3'd1, 3'd1);
    wait_done(400, k, b);
    chk("post_rst_msg_done", 32'(k), 32'(FR + 1));

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
